// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one shared single-outstanding memory.
// Optional build macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed DM priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             if_elig;
  logic             dm_elig;
  logic             pick_dm;
  logic             timeout;

  // A port whose ready is pulsing this cycle is still showing the old request.
  assign if_elig = if_req_i & ~if_ready_o;
  assign dm_elig = dm_req_i & ~dm_ready_o;

`ifdef MEM_ARB_RR_EN
  logic last_dm;
  assign pick_dm = dm_elig & (~if_elig | ~last_dm);
`else
  assign pick_dm = dm_elig;
`endif

  // Fires on the last permitted grant cycle; an ack in that same cycle still wins.
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign if_stall_o = if_req_i & ~if_ready_o;
  assign dm_stall_o = dm_req_i & ~dm_ready_o;

  // NOTE: all state below is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      err_o       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dm     <= 1'b0;
`endif
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (if_elig || dm_elig) begin
            state       <= pick_dm ? GRANT_DM : GRANT_IF;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= pick_dm & dm_we_i;
            mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
            last_dm     <= pick_dm;
`endif
          end
        end
        GRANT_IF, GRANT_DM: begin
          if (mem_ack_i || timeout) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            if (!mem_ack_i) err_o <= 1'b1;
            if (state == GRANT_IF) begin
              if_ready_o <= 1'b1;
              if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end else begin
              dm_ready_o <= 1'b1;
              if (!mem_ack_i)     dm_rdata_o <= '0;
              else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at issue time and
// matched against ready pulses; build with +define+MEM_ARB_RR_EN to exercise round-robin.
module tb_mem_arbiter;

  localparam int TIMEOUT = 8;

  typedef struct {
    bit          dm;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        if_stall_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        err_o;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;
  bit          exp_err = 1'b0;
  bit          last_dm = 1'b0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Every ready pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin : monitor
    exp_t        e;
    logic        rdy;
    logic [31:0] rd;
    for (int p = 0; p < 2; p++) begin
      rdy = (p == 1) ? dm_ready_o : if_ready_o;
      rd  = (p == 1) ? dm_rdata_o : if_rdata_o;
      if (rdy === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_ready port=%0d got data=%h, none expected", p, rd);
        end else begin
          e = sb.pop_front();
          if (e.dm !== (p == 1) || e.data !== rd || e.err !== err_o) begin
            failures++;
            $display("FAIL sb_completion got port=%0d data=%h err=%b expected port=%0d data=%h err=%b",
                     p, rd, err_o, e.dm, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transaction from a single requester; request held until its ready.
  task automatic xact(input bit dm, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int k, input bit no_ack,
                      input logic [31:0] rd, output int req_cyc, output int stall_cyc);
    int   done;
    exp_t e;
    logic rdy;
    logic stl;
    done = no_ack ? TIMEOUT + 1 : k + 2;
    @(posedge clk_i); #1;
    if (dm) begin
      dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    e.dm  = dm;
    e.err = exp_err | no_ack;
    if (no_ack)        e.data = '0;
    else if (dm && we) e.data = exp_dm_rd;
    else               e.data = rd;
    if (dm) exp_dm_rd = e.data; else exp_if_rd = e.data;
    exp_err = e.err;
    last_dm = dm;
    sb.push_back(e);
    req_cyc   = 0;
    stall_cyc = 0;
    for (int c = 0; c <= done; c++) begin
      if (c == 1) begin
        dm_addr_i = ~addr; if_addr_i = ~addr; dm_wdata_i = ~wdata; dm_we_i = ~we;
      end
      if (!no_ack && c == k + 1) begin
        mem_ack_i = 1'b1; mem_rdata_i = rd;
      end
      @(negedge clk_i);
      rdy = dm ? dm_ready_o : if_ready_o;
      stl = dm ? dm_stall_o : if_stall_o;
      if (mem_req_o === 1'b1) begin
        req_cyc++;
        checks++;
        if (mem_addr_o !== addr || mem_we_o !== (dm & we) || (dm && we && mem_wdata_o !== wdata)) begin
          failures++;
          $display("FAIL xact_mem_bus cyc=%0d got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   c, mem_addr_o, mem_we_o, mem_wdata_o, addr, dm & we, wdata);
        end
      end
      if (stl === 1'b1) stall_cyc++;
      checks++;
      if (rdy !== (c == done)) begin
        failures++;
        $display("FAIL xact_ready_timing cyc=%0d got ready=%b expected %b", c, rdy, c == done);
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL xact_no_reissue got mem_req_o=%b expected 0", mem_req_o);
    end
    checks++;
    if (stall_cyc != done) begin
      failures++;
      $display("FAIL xact_stall_cycles got %0d expected %0d", stall_cyc, done);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o, if_stall_o, dm_stall_o} !== 7'b0 ||
        mem_addr_o !== '0 || mem_wdata_o !== '0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
      failures++;
      $display("FAIL reset_values got req=%b we=%b ir=%b dr=%b err=%b addr=%h wd=%h ird=%h drd=%h expected all 0",
               mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o, mem_addr_o, mem_wdata_o,
               if_rdata_o, dm_rdata_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single_fetch();
    int rc, sc;
    xact(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h00A00093, rc, sc);
    checks++;
    if (rc != 1) begin
      failures++;
      $display("FAIL single_fetch_req_cycles got %0d expected 1", rc);
    end
  endtask

  task automatic test_tie();
    exp_t e;
    bit   win_dm;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if_req_i = 1'b1; if_addr_i = 32'h40 + i;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h55;
`ifdef MEM_ARB_RR_EN
      win_dm = !last_dm;
`else
      win_dm = 1'b1;
`endif
      last_dm = win_dm;
      e.dm  = win_dm;
      e.err = exp_err;
      e.data = win_dm ? exp_dm_rd : 32'h1000 + i;
      if (!win_dm) exp_if_rd = e.data;
      sb.push_back(e);
      @(posedge clk_i); #1;
      if_req_i = 1'b0; dm_req_i = 1'b0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1000 + i;
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== win_dm || mem_addr_o !== (win_dm ? 32'h20 : 32'h40 + i)) begin
        failures++;
        $display("FAIL tie_winner rep=%0d got req=%b we=%b addr=%h expected winner dm=%b",
                 i, mem_req_o, mem_we_o, mem_addr_o, win_dm);
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (dm_ready_o !== win_dm || if_ready_o !== !win_dm) begin
        failures++;
        $display("FAIL tie_ready rep=%0d got dm_ready=%b if_ready=%b expected dm winner=%b",
                 i, dm_ready_o, if_ready_o, win_dm);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_dm_read();
    int rc, sc;
    xact(1'b1, 1'b0, 32'h30, 32'h0, 2, 1'b0, 32'hDEADBEEF, rc, sc);
    checks++;
    if (rc != 3) begin
      failures++;
      $display("FAIL dm_read_req_cycles got %0d expected 3", rc);
    end
  endtask

  task automatic test_dm_write_delayed();
    int rc, sc;
    xact(1'b1, 1'b1, 32'h20, 32'h55, 5, 1'b0, 32'h12345678, rc, sc);
    checks++;
    if (rc != 6 || sc != 7) begin
      failures++;
      $display("FAIL dm_write_delayed got req_cycles=%0d stall_cycles=%0d expected 6 and 7", rc, sc);
    end
  endtask

  task automatic test_ack_at_limit();
    int rc, sc;
    xact(1'b0, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFEF00D, rc, sc);
    checks++;
    if (rc != TIMEOUT || err_o !== 1'b0) begin
      failures++;
      $display("FAIL ack_at_limit got req_cycles=%0d err=%b expected %0d and 0", rc, err_o, TIMEOUT);
    end
  endtask

  task automatic test_idle_ack();
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b0 || if_rdata_o !== exp_if_rd || dm_rdata_o !== exp_dm_rd) begin
      failures++;
      $display("FAIL idle_ack got req=%b ird=%h drd=%h expected 0 %h %h",
               mem_req_o, if_rdata_o, dm_rdata_o, exp_if_rd, exp_dm_rd);
    end
  endtask

  task automatic test_back_to_back();
    int rc, sc;
    xact(1'b0, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'h11111111, rc, sc);
    xact(1'b0, 1'b0, 32'h104, 32'h0, 1, 1'b0, 32'h22222222, rc, sc);
    xact(1'b1, 1'b0, 32'h200, 32'h0, 0, 1'b0, 32'h33333333, rc, sc);
  endtask

  task automatic test_timeout();
    int rc, sc;
    xact(1'b0, 1'b0, 32'h80, 32'h0, 0, 1'b1, 32'h0, rc, sc);
    checks++;
    if (rc != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_req_cycles got %0d expected %0d", rc, TIMEOUT);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err_sticky got err=%b expected 1", err_o);
    end
    xact(1'b1, 1'b0, 32'h84, 32'h0, 1, 1'b0, 32'h5A5A5A5A, rc, sc);
  endtask

  task automatic test_reset_mid_grant();
    int rc, sc;
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h34;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_grant_active got mem_req_o=%b expected 1", mem_req_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; dm_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    exp_if_rd = '0; exp_dm_rd = '0; exp_err = 1'b0; last_dm = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b0 || dm_ready_o !== 1'b0 || err_o !== 1'b0 || dm_rdata_o !== '0) begin
      failures++;
      $display("FAIL rst_mid_grant got req=%b dm_ready=%b err=%b drd=%h expected 0 0 0 0",
               mem_req_o, dm_ready_o, err_o, dm_rdata_o);
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b0 || dm_ready_o !== 1'b0 || dm_rdata_o !== '0) begin
      failures++;
      $display("FAIL rst_late_ack got req=%b dm_ready=%b drd=%h expected 0 0 0",
               mem_req_o, dm_ready_o, dm_rdata_o);
    end
    xact(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h00A00093, rc, sc);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_dm_read();
    test_dm_write_delayed();
    test_ack_at_limit();
    test_idle_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    repeat (2) @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending completions expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32: width of all data ports.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: number of grant cycles without mem_ack_i before abort.
REQ-004 SHALL have port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-006 SHALL have ports if_req_i  input  1, and if_addr_i  input  ADDR_W: instruction-fetch read request and address.
REQ-007 SHALL have ports if_rdata_o  output  DATA_W, and if_ready_o  output  1: fetch data, and its one-cycle completion pulse.
REQ-008 SHALL have port if_stall_o  output  1: fetch stage stall (PC and IF/ID hold).
REQ-009 SHALL have ports dm_req_i  input  1, dm_we_i  input  1, dm_addr_i  input  ADDR_W, and dm_wdata_i  input  DATA_W: data-stage request.
REQ-010 SHALL have ports dm_rdata_o  output  DATA_W, dm_ready_o  output  1, and dm_stall_o  output  1: data-stage response and stall.
REQ-011 SHALL have ports mem_req_o  output  1, mem_we_o  output  1, mem_addr_o  output  ADDR_W, and mem_wdata_o  output  DATA_W: shared memory request.
REQ-012 SHALL have ports mem_rdata_i  input  DATA_W, and mem_ack_i  input  1: shared memory read data and completion.
REQ-013 SHALL have port err_o  output  1: sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_IF and GRANT_DM, with exactly one transaction outstanding at a time.
REQ-015 In IDLE, an eligible request SHALL move the FSM to GRANT_IF or GRANT_DM at the next edge, registering addr, we and wdata from the winning requester.
REQ-016 Without a tie, the single requester SHALL win; on a tie, the winner SHALL be selected per REQ-030/REQ-031.
REQ-017 mem_req_o SHALL be high in every GRANT cycle; mem_addr_o, mem_we_o and mem_wdata_o SHALL be driven from the registered copies, stable until ack; mem_we_o SHALL be 0 in GRANT_IF.
REQ-018 A request SHALL complete as follows:
- request high in cycle N, memory slow by k cycles (k >= 0): mem_req_o high in cycles N+1..N+1+k, mem_ack_i high in cycle N+1+k;
- in cycle N+2+k: the requester's ready_o is high for exactly one cycle and the FSM is in IDLE;
- minimum request-to-ready latency is 2 cycles.
REQ-019 On ack of a read, the arbiter SHALL capture mem_rdata_i into the granted requester's rdata_o register; rdata_o SHALL hold until the next read completion for that port.
REQ-020 On ack of a write, dm_ready_o SHALL pulse and dm_rdata_o SHALL remain unchanged.
REQ-021 if_stall_o SHALL equal if_req_i & ~if_ready_o, and dm_stall_o SHALL equal dm_req_i & ~dm_ready_o (combinational).
REQ-022 A requester's req_i SHALL be ineligible for arbitration in the cycle its ready_o is high (no double issue).
REQ-023 Deasserting req_i or changing addr/wdata mid-grant SHALL NOT affect the transaction in flight; it completes using the registered values.
REQ-024 mem_ack_i in IDLE SHALL be ignored.
REQ-025 A wait counter SHALL clear on grant entry and increment each GRANT cycle without ack.
REQ-026 When the wait counter reaches TIMEOUT_CYC without ack, the arbiter SHALL:
- drop mem_req_o the next cycle;
- pulse the granted ready_o with rdata_o = 0;
- set err_o;
- return to IDLE.
REQ-027 An ack arriving in the same cycle the wait counter reaches TIMEOUT_CYC SHALL take precedence over the timeout (normal completion, err_o unchanged).

Reset
REQ-028 While rst_i is high at an edge, the arbiter SHALL reset: FSM to IDLE; mem_req_o, mem_we_o, if_ready_o, dm_ready_o and err_o to 0; mem_addr_o, mem_wdata_o, if_rdata_o and dm_rdata_o to 0; wait counter to 0; last-grant register to IF.
REQ-029 Reset mid-grant SHALL abandon the transaction, with no ready pulse; an ack arriving after reset SHALL be ignored per REQ-024.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, ties SHALL be granted to the port not granted last; the last-grant register SHALL update on every grant, so the first tie after reset goes to DM.
REQ-031 Without MEM_ARB_RR_EN, ties SHALL always be granted to DM (fixed priority), and no last-grant register SHALL be synthesized.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Single fetch, if_addr_i=0x10, ack in the cycle after mem_req_o rises with mem_rdata_i=0x00A00093 -> if_ready_o pulses 2 cycles after if_req_i, if_rdata_o=0x00A00093, if_stall_o low in the ready cycle only.
- Simultaneous requests repeated 4 times, DM write addr 0x20 data 0x55 -> fixed priority: DM granted all 4; with MEM_ARB_RR_EN: order DM, IF, DM, IF.
- DM write with ack delayed by 5 cycles -> mem_req_o high 6 cycles, mem_we_o=1, addr 0x20 stable, dm_stall_o high for 7 cycles, dm_rdata_o unchanged.
- No ack with TIMEOUT_CYC=8 -> mem_req_o drops after 8 wait cycles, ready pulses with rdata 0, err_o stays 1 until rst_i.
- rst_i asserted in the 2nd cycle of GRANT_DM, then an ack 1 cycle later -> no dm_ready_o pulse, mem_req_o 0 after the reset edge, FSM idle.
